freq_gen: RTL
=============

Name: freq_gen

Overview:
Programmable square-wave generator, the stimulus source that pairs with the auto-scaled frequency counter. A binary frequency request in Hz is latched on start. A sequential restoring divider computes the half-period in clock cycles, and a run counter then toggles sig indefinitely. Its output feeds the counter's sig input in loop-back and board self-test builds.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz; must be even.
FREQ_W, 20, width of freq request; max request 1_048_575 Hz.
CNT_W, 26, width of dividend/quotient/run counter; must satisfy 2^CNT_W > CLK_HZ/2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: latch freq and (re)compute
stop  in  1  one-cycle pulse: halt output
freq  in  FREQ_W  requested frequency in Hz, unsigned
sig  out  1  generated square wave
busy  out  1  high while the divider runs
done_tick  out  1  one-cycle pulse when the new half-period is loaded
half_per  out  CNT_W  current half-period in cycles; 0 = stopped

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sig=0, busy=0, done_tick=0, half_per=0, counters cleared.
- States: IDLE, DIV, RUN. All outputs are registered.
- IDLE:
  - start=1: latch freq into divisor register; dividend=CLK_HZ/2; go DIV; busy=1 next cycle.
  - stop ignored.
- DIV: restoring division, one quotient bit per cycle, MSB first, exactly CNT_W cycles.
  - start and stop ignored.
  - After the last iteration: half_per = max(quotient,1) (truncating); done_tick=1 for one cycle; busy=0; run counter=0; go RUN.
  - Latency: start sampled at edge k gives done_tick high after edge k+CNT_W+1.
- freq=0: skip division. One cycle after start: half_per=0, sig=0, done_tick=1, state IDLE.
- RUN: counter increments each cycle.
  - When counter = half_per-1: sig toggles and counter returns to 0.
  - Resulting period is 2*half_per cycles at 50% duty.
  - The first toggle occurs half_per cycles after done_tick.
- start in RUN: latch new freq, go DIV. sig holds its current level and the counter freezes during DIV. Toggling restarts from counter 0 with the new half_per.
- stop in RUN: next cycle sig=0, half_per=0, counter=0, state IDLE.
- start and stop in the same cycle: start wins in IDLE and RUN.
- freq > CLK_HZ/2 gives quotient 0. Clamp to half_per=1, so sig toggles every cycle at CLK_HZ/2.
- Reset mid-DIV or mid-RUN: immediate return to reset values; no done_tick.
- Widths:
  - Divider remainder is CNT_W+1 bits; divisor is zero-extended from FREQ_W.
  - Run counter is CNT_W bits and never exceeds half_per-1.

Test Plan:
- Reset, then start with freq=10 -> done_tick exactly CNT_W+1 cycles later; half_per=5_000_000; sig toggles every 5_000_000 cycles (100 ms period at 100 MHz). Feeding sig to the frequency counter displays 10.
- freq=3 -> half_per=16_666_666 (truncated); measure the toggle interval.
- freq=1_048_575 -> half_per=47, sig period 94 cycles. Use CLK_HZ=100 with freq=60 -> half_per clamps to 1, sig toggles every cycle.
- freq=0 from RUN -> done_tick the next cycle, half_per=0, sig stays 0, state IDLE.
- Start during DIV (pulse at cycle 5 of division) -> ignored; original result is loaded and a single done_tick occurs. Start in RUN with sig=1 -> sig stays 1 through DIV, then toggles half_per cycles after the new done_tick.
- Stop in RUN -> sig=0 next cycle. Start and stop in the same cycle -> start wins. Assert rst_n=0 mid-DIV -> all outputs zero immediately, no done_tick after release.

Source files
------------

// File: rtl/freq_gen_if.sv
// freq_gen_if: request/status bundle between a controller and the square-wave generator
interface freq_gen_if #(
    parameter int FREQ_W = 20,
    parameter int CNT_W  = 26
) ();
    logic              start;
    logic              stop;
    logic [FREQ_W-1:0] freq;
    logic              sig;
    logic              busy;
    logic              done_tick;
    logic [CNT_W-1:0]  half_per;

    modport master (output start, stop, freq, input sig, busy, done_tick, half_per);
    modport slave  (input start, stop, freq, output sig, busy, done_tick, half_per);
endinterface

// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave source; half-period = (CLK_HZ/2)/freq via restoring divider
module freq_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int FREQ_W = 20,
    parameter int CNT_W  = 26
) (
    input logic       clk,
    input logic       rst_n,
    freq_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

    localparam int              IW   = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_HZ / 2);

    state_t            state;
    logic [FREQ_W-1:0] divisor;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  quo;
    logic [CNT_W-1:0]  cnt;
    logic [IW-1:0]     idx;
    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    dvs;
    logic              ge;

    // one restoring step: shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        dvs   = (CNT_W + 1)'(divisor);
        trial = {rem, quo[CNT_W-1]};
        ge    = trial >= dvs;
    end

    // control FSM: request latch, bit-serial division, then free-running half-period toggling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            divisor       <= '0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            idx           <= '0;
            bus.sig       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done_tick <= 1'b0;
            bus.half_per  <= '0;
        end else begin
            bus.done_tick <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (bus.start) begin
                        if (bus.freq == '0) begin
                            bus.half_per  <= '0;
                            bus.sig       <= 1'b0;
                            bus.done_tick <= 1'b1;
                            cnt           <= '0;
                            state         <= IDLE;
                        end else begin
                            divisor  <= bus.freq;
                            rem      <= '0;
                            quo      <= HALF;
                            idx      <= '0;
                            bus.busy <= 1'b1;
                            state    <= DIV;
                        end
                    end else if (state == RUN) begin
                        if (bus.stop) begin
                            bus.sig      <= 1'b0;
                            bus.half_per <= '0;
                            cnt          <= '0;
                            state        <= IDLE;
                        end else if (cnt == bus.half_per - 1'b1) begin
                            bus.sig <= ~bus.sig;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DIV: begin
                    if (idx == IW'(CNT_W)) begin
                        bus.half_per  <= (quo == '0) ? CNT_W'(1) : quo;
                        bus.done_tick <= 1'b1;
                        bus.busy      <= 1'b0;
                        cnt           <= '0;
                        state         <= RUN;
                    end else begin
                        rem <= ge ? CNT_W'(trial - dvs) : CNT_W'(trial);
                        quo <= {quo[CNT_W-2:0], ge};
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
